// File: rtl/result_bcd.sv
// rtl/result_bcd.sv - sequential double-dabble BCD converter for divider quotient/remainder
// Optional remainder conversion is enabled with `define BCD_REMAINDER_EN.
module result_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  Q,
  input  logic [7:0]  R,
  input  logic        div_zero,
  output logic [11:0] q_bcd,
  output logic [11:0] r_bcd,
  output logic        err,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV_Q = 2'd1;
  localparam logic [1:0] ST_CONV_R = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  q_op_q, q_op_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] q_bcd_q, q_bcd_d;
  logic [11:0] r_bcd_q, r_bcd_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [19:0] q_step;

`ifdef BCD_REMAINDER_EN
  logic [7:0]  r_op_q, r_op_d;
  logic [11:0] q_dig_q, q_dig_d;
  logic [19:0] r_step;
`else
  logic        unused_r;
  assign unused_r = ^R;
`endif

  // One iteration: add 3 to every digit >= 5, then shift {scratch, operand} left.
  function automatic logic [19:0] dabble_step(input logic [11:0] s, input logic [7:0] op);
    logic [11:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (s[4*i +: 4] >= 4'd5) a[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return {a, op} << 1;
  endfunction

  assign q_step = dabble_step(scratch_q, q_op_q);
`ifdef BCD_REMAINDER_EN
  assign r_step = dabble_step(scratch_q, r_op_q);
`endif

  always_comb begin
    state_d   = state_q;
    q_op_d    = q_op_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    q_bcd_d   = q_bcd_q;
    r_bcd_d   = r_bcd_q;
    err_d     = err_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef BCD_REMAINDER_EN
    r_op_d    = r_op_q;
    q_dig_d   = q_dig_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_op_d    = Q;
`ifdef BCD_REMAINDER_EN
          r_op_d    = R;
`endif
          scratch_d = 12'd0;
          cnt_d     = 3'd0;
          if (div_zero) begin
            q_bcd_d = 12'hFFF;
            r_bcd_d = 12'hFFF;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_CONV_Q;
          end
        end
      end
      ST_CONV_Q: begin
        {scratch_d, q_op_d} = q_step;
        cnt_d  = cnt_q + 3'd1;
        busy_d = 1'b1;
        if (cnt_q == 3'd7) begin
`ifdef BCD_REMAINDER_EN
          q_dig_d   = q_step[19:8];
          scratch_d = 12'd0;
          state_d   = ST_CONV_R;
`else
          q_bcd_d = q_step[19:8];
          r_bcd_d = 12'd0;
          err_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
`endif
        end
      end
`ifdef BCD_REMAINDER_EN
      ST_CONV_R: begin
        {scratch_d, r_op_d} = r_step;
        cnt_d  = cnt_q + 3'd1;
        busy_d = 1'b1;
        if (cnt_q == 3'd7) begin
          q_bcd_d = q_dig_q;
          r_bcd_d = r_step[19:8];
          err_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      q_op_q    <= 8'd0;
      scratch_q <= 12'd0;
      cnt_q     <= 3'd0;
      q_bcd_q   <= 12'd0;
      r_bcd_q   <= 12'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_REMAINDER_EN
      r_op_q    <= 8'd0;
      q_dig_q   <= 12'd0;
`endif
    end else begin
      state_q   <= state_d;
      q_op_q    <= q_op_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      q_bcd_q   <= q_bcd_d;
      r_bcd_q   <= r_bcd_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BCD_REMAINDER_EN
      r_op_q    <= r_op_d;
      q_dig_q   <= q_dig_d;
`endif
    end
  end

  assign q_bcd = q_bcd_q;
  assign r_bcd = r_bcd_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_result_bcd.sv
// tb/tb_result_bcd.sv - directed self-checking bench for result_bcd
module tb_result_bcd;

`ifdef BCD_REMAINDER_EN
  localparam int LAT = 16;
  localparam bit REM_EN = 1'b1;
`else
  localparam int LAT = 8;
  localparam bit REM_EN = 1'b0;
`endif
  localparam int WIN = LAT + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  Q = 8'd0;
  logic [7:0]  R = 8'd0;
  logic        div_zero = 1'b0;
  logic [11:0] q_bcd, r_bcd;
  logic        err, busy, done;

  int checks = 0;
  int errors = 0;

  result_bcd dut (
    .clk(clk), .reset(reset), .start(start), .Q(Q), .R(R), .div_zero(div_zero),
    .q_bcd(q_bcd), .r_bcd(r_bcd), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_r(input logic [11:0] digits);
    return REM_EN ? digits : 12'h000;
  endfunction

  // Issues one request, then observes WIN samples (sample k follows edge N+k-1).
  // If inj_k > 0, start is re-driven with Q=99 for the edge N+inj_k.
  task automatic conv(input logic [7:0] qv, input logic [7:0] rv, input logic dz,
                      input int inj_k, output int done_at, output int done_cnt,
                      output int busy_cnt, output int overlap);
    done_at = 0; done_cnt = 0; busy_cnt = 0; overlap = 0;
    Q = qv; R = rv; div_zero = dz; start = 1'b1;
    tick();
    start = 1'b0; Q = ~qv; R = ~rv; div_zero = ~dz;
    for (int k = 1; k <= WIN; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (busy && done) overlap++;
      start = (k == inj_k);
      if (k == inj_k) Q = 8'd99;
      tick();
    end
    start = 1'b0; div_zero = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (q_bcd !== 12'h000 || r_bcd !== 12'h000 || err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%h r=%h err=%b busy=%b done=%b, required all 0", q_bcd, r_bcd, err, busy, done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int da, dc, bc, ov;
    conv(8'd5, 8'd0, 1'b0, 0, da, dc, bc, ov);
    checks++;
    if (q_bcd !== 12'h005) begin errors++; $display("FAIL basic_q: got %h required 005", q_bcd); end
    checks++;
    if (r_bcd !== 12'h000 || err !== 1'b0) begin errors++; $display("FAIL basic_r_err: got r=%h err=%b required 000/0", r_bcd, err); end
    checks++;
    if (da !== LAT + 1 || dc !== 1) begin errors++; $display("FAIL basic_done: at=%0d count=%0d required at=%0d count=1", da, dc, LAT + 1); end
  endtask

  task automatic test_values();
    int da, dc, bc, ov;
    conv(8'd25, 8'd5, 1'b0, 0, da, dc, bc, ov);
    checks++;
    if (q_bcd !== 12'h025 || r_bcd !== exp_r(12'h005)) begin errors++; $display("FAIL val_25_5: got %h/%h required 025/%h", q_bcd, r_bcd, exp_r(12'h005)); end
    checks++;
    if (bc !== LAT) begin errors++; $display("FAIL busy_len: got %0d required %0d", bc, LAT); end
    checks++;
    if (ov !== 0) begin errors++; $display("FAIL busy_done_overlap: got %0d required 0", ov); end
    conv(8'd255, 8'd254, 1'b0, 0, da, dc, bc, ov);
    checks++;
    if (q_bcd !== 12'h255 || r_bcd !== exp_r(12'h254)) begin errors++; $display("FAIL val_255_254: got %h/%h required 255/%h", q_bcd, r_bcd, exp_r(12'h254)); end
    conv(8'd0, 8'd0, 1'b0, 0, da, dc, bc, ov);
    checks++;
    if (q_bcd !== 12'h000 || r_bcd !== 12'h000) begin errors++; $display("FAIL val_0_0: got %h/%h required 000/000", q_bcd, r_bcd); end
    conv(8'd199, 8'd68, 1'b0, 0, da, dc, bc, ov);
    checks++;
    if (q_bcd !== 12'h199 || r_bcd !== exp_r(12'h068)) begin errors++; $display("FAIL val_199_68: got %h/%h required 199/%h", q_bcd, r_bcd, exp_r(12'h068)); end
  endtask

  task automatic test_div_zero();
    int da, dc, bc, ov;
    conv(8'd100, 8'd3, 1'b1, 0, da, dc, bc, ov);
    checks++;
    if (err !== 1'b1 || q_bcd !== 12'hFFF || r_bcd !== 12'hFFF) begin errors++; $display("FAIL dz_outputs: got err=%b q=%h r=%h required 1/FFF/FFF", err, q_bcd, r_bcd); end
    checks++;
    if (da !== 1 || dc !== 1) begin errors++; $display("FAIL dz_done: at=%0d count=%0d required at=1 count=1", da, dc); end
    checks++;
    if (bc !== 0) begin errors++; $display("FAIL dz_busy: got %0d busy cycles required 0", bc); end
    conv(8'd7, 8'd3, 1'b0, 0, da, dc, bc, ov);
    checks++;
    if (err !== 1'b0 || q_bcd !== 12'h007 || r_bcd !== exp_r(12'h003)) begin errors++; $display("FAIL dz_clear: got err=%b q=%h r=%h required 0/007/%h", err, q_bcd, r_bcd, exp_r(12'h003)); end
  endtask

  task automatic test_ignore_start();
    int da, dc, bc, ov;
    conv(8'd17, 8'd2, 1'b0, 4, da, dc, bc, ov);
    checks++;
    if (q_bcd !== 12'h017 || r_bcd !== exp_r(12'h002)) begin errors++; $display("FAIL ignore_result: got %h/%h required 017/%h", q_bcd, r_bcd, exp_r(12'h002)); end
    checks++;
    if (dc !== 1 || da !== LAT + 1) begin errors++; $display("FAIL ignore_done: count=%0d at=%0d required count=1 at=%0d", dc, da, LAT + 1); end
  endtask

  task automatic test_reset_mid();
    int da, dc, bc, ov;
    int seen;
    Q = 8'd200; R = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 6; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (q_bcd !== 12'h000 || r_bcd !== 12'h000 || err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got q=%h r=%h err=%b busy=%b done=%b required all 0", q_bcd, r_bcd, err, busy, done);
    end
    seen = 0;
    for (int k = 0; k < WIN; k++) begin
      if (done || busy) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d active cycles required 0", seen); end
    conv(8'd42, 8'd1, 1'b0, 0, da, dc, bc, ov);
    checks++;
    if (q_bcd !== 12'h042 || r_bcd !== exp_r(12'h001) || dc !== 1) begin
      errors++;
      $display("FAIL after_reset: got %h/%h done=%0d required 042/%h done=1", q_bcd, r_bcd, dc, exp_r(12'h001));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
